// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a req/ack data-memory port that stalls the front of the pipe.
// Optional access timeout with sticky error: define EX_MEM_TIMEOUT_EN.
module ex_mem_reg #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ALUres_i,
  input  logic [31:0] RS2Data_i,
  input  logic [31:0] inst_i,
  input  logic        valid_i,
  input  logic [2:0]  MEM_signal_i,
  input  logic [1:0]  WB_signal_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] ALUres_o,
  output logic [31:0] MemData_o,
  output logic [4:0]  RDaddr_o,
  output logic [1:0]  WB_signal_o,
  output logic        err_o
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_valid;
  logic [31:0] r_alures;
  logic [31:0] r_memdata;
  logic [4:0]  r_rd;
  logic [1:0]  r_wb;
  logic [2:0]  r_mem;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_capture_valid;
  logic        w_mem_access;
  logic        w_load;
  logic        w_timeout;
  logic        w_unused;

  assign w_capture_valid = valid_i & ~flush_i;
  assign w_mem_access    = w_capture_valid & (MEM_signal_i[0] | MEM_signal_i[1]);
  // MemRead with MemWrite also set is a store, so only a pure read loads.
  assign w_load          = r_mem[1] & ~r_mem[0];
  assign w_unused        = ^{inst_i[31:12], inst_i[6:0], r_mem[2]};

`ifdef EX_MEM_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_next;
  logic        r_err;

  assign w_cnt_next = r_cnt + 32'd1;
  // This edge ends the TIMEOUT_CYC-th ACCESS cycle without ack; a same-cycle ack wins.
  assign w_timeout  = (r_state == ACCESS) && !dmem_ack_i && (w_cnt_next == TIMEOUT_CYC);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_cnt <= '0;
      end else if (!dmem_ack_i) begin
        r_cnt <= w_cnt_next;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign w_unused_cfg = (TIMEOUT_CYC == 32'd0);
  assign err_o        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_mem_access) w_state_next = ACCESS;
      ACCESS:  if (dmem_ack_i || w_timeout) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_o = (r_state == ACCESS);
    valid_o = r_valid && (r_state == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_valid   <= 1'b0;
      r_alures  <= '0;
      r_memdata <= '0;
      r_rd      <= '0;
      r_wb      <= '0;
      r_mem     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (r_state == IDLE) begin
      r_valid  <= w_capture_valid;
      r_alures <= ALUres_i;
      r_rd     <= inst_i[11:7];
      r_wb     <= flush_i ? 2'b00 : WB_signal_i;
      r_mem    <= flush_i ? 3'b000 : MEM_signal_i;
      if (w_mem_access) begin
        r_req   <= 1'b1;
        r_we    <= MEM_signal_i[0];
        r_addr  <= ALUres_i;
        r_wdata <= RS2Data_i;
      end
    end else if (dmem_ack_i) begin
      if (w_load) begin
        r_memdata <= dmem_rdata_i;
      end
      r_req <= 1'b0;
      r_we  <= 1'b0;
    end else if (w_timeout) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_memdata <= '0;
      r_wb[0]   <= 1'b0;
    end
  end

  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign ALUres_o     = r_alures;
  assign MemData_o    = r_memdata;
  assign RDaddr_o     = r_rd;
  assign WB_signal_o  = r_wb;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: stimulus pushes expected entries, a monitor pops them on valid_o.
`timescale 1ns/1ps
module tb_ex_mem_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] ALUres_i;
  logic [31:0] RS2Data_i;
  logic [31:0] inst_i;
  logic        valid_i;
  logic [2:0]  MEM_signal_i;
  logic [1:0]  WB_signal_i;
  logic        flush_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] ALUres_o;
  logic [31:0] MemData_o;
  logic [4:0]  RDaddr_o;
  logic [1:0]  WB_signal_o;
  logic        err_o;

  ex_mem_reg #(.TIMEOUT_CYC(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ALUres_i     (ALUres_i),
    .RS2Data_i    (RS2Data_i),
    .inst_i       (inst_i),
    .valid_i      (valid_i),
    .MEM_signal_i (MEM_signal_i),
    .WB_signal_i  (WB_signal_i),
    .flush_i      (flush_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .stall_o      (stall_o),
    .valid_o      (valid_o),
    .ALUres_o     (ALUres_o),
    .MemData_o    (MemData_o),
    .RDaddr_o     (RDaddr_o),
    .WB_signal_o  (WB_signal_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mdata;
    logic [4:0]  rd;
    logic [1:0]  wb;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_memdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every presented entry must match the oldest expected one.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i === 1'b1 && valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got valid_o=1 expected no entry");
      end else begin
        e = exp_q.pop_front();
        chk("sb_alures", ALUres_o, e.alu);
        chk("sb_memdata", MemData_o, e.mdata);
        chk("sb_rd", 32'(RDaddr_o), 32'(e.rd));
        chk("sb_wb", 32'(WB_signal_o), 32'(e.wb));
      end
    end
  end

  task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                       input logic [2:0] mem, input logic [1:0] wb, input logic v, input logic fl);
    ALUres_i     = alu;
    RS2Data_i    = rs2;
    inst_i       = {20'hABCDE, rd, 7'h33};
    MEM_signal_i = mem;
    WB_signal_i  = wb;
    valid_i      = v;
    flush_i      = fl;
  endtask

  task automatic bubble();
    drive(32'h0, 32'h0, 5'd0, 3'b000, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd, input logic [1:0] wb);
    drive(alu, 32'h5555_5555, rd, 3'b000, wb, 1'b1, 1'b0);
    exp_q.push_back('{alu, m_memdata, rd, wb});
    @(posedge clk_i); #1;
    bubble();
    @(negedge clk_i);
    chk("alu_stall", 32'(stall_o), 32'd0);
    chk("alu_req", 32'(dmem_req_o), 32'd0);
  endtask

  task automatic run_access(input int delay, input logic [31:0] rdata, input logic exp_we,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                            input logic flush_mid);
    int stalls = 0;
    for (int k = 0; k <= delay; k++) begin
      dmem_ack_i   = (k == delay);
      dmem_rdata_i = (k == delay) ? rdata : (32'hBAD0_0000 | 32'(k));
      if (flush_mid) drive(32'hFFFF_F000, 32'hEEEE_EEEE, 5'd31, 3'b010, 2'b11, 1'b1, 1'b1);
      @(negedge clk_i);
      if (stall_o) stalls++;
      chk("acc_req", 32'(dmem_req_o), 32'd1);
      chk("acc_we", 32'(dmem_we_o), 32'(exp_we));
      chk("acc_addr", dmem_addr_o, exp_addr);
      chk("acc_wdata", dmem_wdata_o, exp_wdata);
      @(posedge clk_i); #1;
    end
    bubble();
    dmem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("acc_stall_cycles", 32'(stalls), 32'(delay + 1));
    chk("acc_stall_after", 32'(stall_o), 32'd0);
    chk("acc_req_after", 32'(dmem_req_o), 32'd0);
  endtask

  task automatic mem_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [2:0] mem, input logic [1:0] wb, input int delay,
                        input logic [31:0] rdata, input logic flush_mid);
    logic is_write;
    is_write = mem[0];
    drive(alu, rs2, rd, mem, wb, 1'b1, 1'b0);
    if (!is_write) m_memdata = rdata;
    exp_q.push_back('{alu, m_memdata, rd, wb});
    @(posedge clk_i); #1;
    bubble();
    run_access(delay, rdata, is_write, alu, rs2, flush_mid);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 32'(dmem_req_o), 32'd0);
    chk({tag, "_we"}, 32'(dmem_we_o), 32'd0);
    chk({tag, "_addr"}, dmem_addr_o, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata_o, 32'd0);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_alures"}, ALUres_o, 32'd0);
    chk({tag, "_memdata"}, MemData_o, 32'd0);
    chk({tag, "_rd"}, 32'(RDaddr_o), 32'd0);
    chk({tag, "_wb"}, 32'(WB_signal_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i        = 1'b0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = '0;
    bubble();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b1;

    alu_op(32'h0000_0010, 5'd5, 2'b01);
    mem_op(32'h0000_0040, 32'h0000_0000, 5'd3, 3'b010, 2'b11, 0, 32'hDEAD_BEEF, 1'b0);
    alu_op(32'h0000_002A, 5'd8, 2'b01);
    mem_op(32'h0000_0080, 32'h0000_1234, 5'd0, 3'b001, 2'b00, 3, 32'h1111_2222, 1'b0);
    mem_op(32'h0000_0084, 32'h0000_5678, 5'd0, 3'b011, 2'b00, 1, 32'h3333_4444, 1'b0);

    // Flushed memory entry: bubble, no request.
    drive(32'h0000_0100, 32'h0000_0077, 5'd9, 3'b010, 2'b11, 1'b1, 1'b1);
    @(posedge clk_i); #1;
    bubble();
    @(negedge clk_i);
    chk("flush_req", 32'(dmem_req_o), 32'd0);
    chk("flush_stall", 32'(stall_o), 32'd0);
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_wb", 32'(WB_signal_o), 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("flush_req_later", 32'(dmem_req_o), 32'd0);

    mem_op(32'h0000_00C0, 32'h0000_00AA, 5'd12, 3'b010, 2'b11, 2, 32'h0BAD_CAFE, 1'b1);

    // Ack while idle must not disturb anything.
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    dmem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("idle_ack_stall", 32'(stall_o), 32'd0);
    chk("idle_ack_memdata", MemData_o, m_memdata);

    mem_op(32'h0000_0044, 32'h0000_0001, 5'd17, 3'b010, 2'b11, 2, 32'h1357_2468, 1'b0);

    // Reset in the 2nd ACCESS cycle; this entry is abandoned.
    drive(32'h0000_0200, 32'h0000_0099, 5'd7, 3'b010, 2'b11, 1'b1, 1'b0);
    @(posedge clk_i); #1;
    bubble();
    @(negedge clk_i);
    chk("rst_mid_req_c1", 32'(dmem_req_o), 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_all_zero("rst_mid");
    rst_i     = 1'b1;
    m_memdata = '0;

    alu_op(32'h0000_0055, 5'd21, 2'b01);

`ifdef EX_MEM_TIMEOUT_EN
    begin
      int st;
      st = 0;
      drive(32'h0000_0300, 32'h0000_0003, 5'd4, 3'b010, 2'b11, 1'b1, 1'b0);
      m_memdata = '0;
      exp_q.push_back('{32'h0000_0300, 32'h0, 5'd4, 2'b10});
      @(posedge clk_i); #1;
      bubble();
      for (int k = 0; k < 20; k++) begin
        @(negedge clk_i);
        if (!stall_o) break;
        st++;
        chk("to_req_held", 32'(dmem_req_o), 32'd1);
        @(posedge clk_i); #1;
      end
      chk("to_stall_cycles", 32'(st), 32'd4);
      chk("to_req_dropped", 32'(dmem_req_o), 32'd0);
      chk("to_err", 32'(err_o), 32'd1);
      alu_op(32'h0000_0066, 5'd22, 2'b01);
      chk("to_err_sticky", 32'(err_o), 32'd1);
    end
`else
    mem_op(32'h0000_0300, 32'h0000_0003, 5'd4, 3'b010, 2'b11, 100, 32'h2468_ACE0, 1'b0);
    chk("no_to_err", 32'(err_o), 32'd0);
`endif

    repeat (3) @(negedge clk_i);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline stage; the consumer side of the ID/EX register outputs.
- Captures the EX-stage result, store data, rd and control bundles.
- Drives a req/ack data-memory port for loads and stores, stalling the front of the pipe until the access completes.
- Presents a completed entry to the MEM/WB register.

Parameters:
- TIMEOUT_CYC, 16, max ACCESS cycles before abort (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- ALUres_i  in  32  EX-stage ALU result (address for load/store)
- RS2Data_i  in  32  store data
- inst_i  in  32  EX-stage instruction; rd = inst_i[11:7]
- valid_i  in  1  EX-stage entry valid
- MEM_signal_i  in  3  [0] MemWrite, [1] MemRead, [2] Branch
- WB_signal_i  in  2  [0] RegWrite, [1] MemtoReg
- flush_i  in  1  kill incoming capture (branch taken)
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  address
- dmem_wdata_o  out  32  write data
- dmem_ack_i  in  1  access complete; dmem_rdata_i valid this cycle
- dmem_rdata_i  in  32  load data
- stall_o  out  1  hold PC, IF/ID, ID/EX
- valid_o  out  1  completed entry available to MEM/WB
- ALUres_o  out  32  registered ALU result
- MemData_o  out  32  load data
- RDaddr_o  out  5  destination register
- WB_signal_o  out  2  registered WB bundle
- err_o  out  1  sticky access timeout (optional feature)

Behaviour:
- FSM states: IDLE, ACCESS.
- Reset (rst_i==0 at an edge):
  - state=IDLE, entry valid=0.
  - ALUres_o, MemData_o, RDaddr_o, WB_signal_o, dmem_addr_o, dmem_wdata_o = 0.
  - dmem_req_o=0, dmem_we_o=0, err_o=0.
- IDLE, each edge: capture ALUres_i, RS2Data_i, inst_i[11:7], MEM_signal_i, WB_signal_i and valid_i. Latency 1 cycle.
- flush_i=1 at a capturing edge: captured entry is a bubble.
  - valid=0, WB_signal_o=0, MEM bundle=0.
  - No memory access.
- Captured entry with valid=1 and MemRead|MemWrite:
  - Next state ACCESS.
  - dmem_req_o=1, dmem_addr_o=ALUres_i, dmem_wdata_o=RS2Data_i, dmem_we_o=MemWrite (all registered at the same edge).
- MemRead and MemWrite both set: treated as write.
- Non-memory valid entry: stays IDLE; MemData_o is left unchanged.
- ACCESS:
  - No capture; inputs ignored; flush_i ignored (flush only kills incoming captures).
  - dmem_req/we/addr/wdata held stable until ack.
- ACCESS with dmem_ack_i=1 at an edge:
  - MemData_o <= dmem_rdata_i (loads only; stores leave it unchanged).
  - dmem_req_o <= 0, dmem_we_o <= 0, state <= IDLE.
- stall_o = (state==ACCESS), combinational.
  - Zero-wait ack (ack in first ACCESS cycle) costs exactly 1 stall cycle.
  - N-cycle-late ack costs N+1 stall cycles.
- valid_o = entry valid && state==IDLE, combinational.
  - MEM/WB samples when valid_o=1.
  - A memory entry is presented exactly once: the cycle after ack.
- The edge leaving ACCESS does not capture; the following IDLE edge captures the held ID/EX output.
- dmem_ack_i while IDLE: ignored.
- Reset during ACCESS: IDLE next edge, request dropped. The memory side must tolerate an abandoned request.

Optional Feature:
- Macro: EX_MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle without ack.
  - When the count reaches TIMEOUT_CYC with no ack, next edge:
    - state=IDLE, dmem_req_o=0, dmem_we_o=0
    - MemData_o=0, WB_signal_o[0]=0 (write-back suppressed)
    - err_o=1, sticky until reset.
  - Ack in the same cycle as the limit wins; no error.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - err_o tied 0.
  - TIMEOUT_CYC unused.

Test Plan:
- ALU op: valid_i=1, ALUres_i=0x0000_0010, inst rd=5, WB=01, MEM=000 -> next cycle valid_o=1, ALUres_o=0x10, RDaddr_o=5, WB_signal_o=01; stall_o never 1; dmem_req_o=0.
- Zero-wait load: MEM=010, ALUres_i=0x40, ack in the first ACCESS cycle with rdata=0xDEADBEEF -> dmem_req_o=1, dmem_we_o=0, addr=0x40 for 1 cycle; stall_o high 1 cycle; then valid_o=1, MemData_o=0xDEADBEEF.
- Store with 3-cycle-late ack: MEM=001, ALUres_i=0x80, RS2Data_i=0x1234 -> req/we/addr/wdata stable 4 cycles; stall_o high 4 cycles; MemData_o unchanged; single valid_o pulse.
- Flush: flush_i=1 with valid_i=1, MEM=010 -> valid_o=0, WB_signal_o=00, no dmem_req_o. Flush asserted during ACCESS -> no effect.
- Reset mid-ACCESS: rst_i=0 during the 2nd ACCESS cycle -> next edge dmem_req_o=0, stall_o=0, all outputs 0.
- Timeout (macro defined, TIMEOUT_CYC=4): load, never ack -> req drops after 4 ACCESS cycles, err_o=1 and stays 1, WB_signal_o[0]=0, MemData_o=0. Without macro -> stall_o stays 1 for 100 cycles, err_o=0.
